// File: rtl/gpio_regs_if.sv
// Bus-side signals of the GPIO register block: address, write strobe, write data and read-back data.
interface gpio_regs_if #(parameter int WIDTH = 32);
   logic [1:0]       A;
   logic             WE;
   logic [WIDTH-1:0] WD;
   logic [WIDTH-1:0] RD;

   modport master (output A, output WE, output WD, input RD);
   modport slave  (input A, input WE, input WD, output RD);
endinterface

// File: rtl/gpio_regs.sv
// Two-port GPIO register block: address decode, two enabled output registers and a read-back mux.
module gpio_regs #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   gpio_regs_if.slave       bus,
   input  logic [WIDTH-1:0] gpI1,
   input  logic [WIDTH-1:0] gpI2,
   output logic [WIDTH-1:0] gpO1,
   output logic [WIDTH-1:0] gpO2
);

   logic             we1_s;
   logic             we2_s;
   logic [WIDTH-1:0] rdMux_s;
   logic [WIDTH-1:0] gpO1_r;
   logic [WIDTH-1:0] gpO2_r;

   // Write-enable decode; addresses 0 and 1 are read-only, so writes there are dropped.
   always_comb begin
      we1_s = 1'b0;
      we2_s = 1'b0;
      if (bus.WE) begin
         case (bus.A)
            2'd2:    we1_s = 1'b1;
            2'd3:    we2_s = 1'b1;
            default: begin
               we1_s = 1'b0;
               we2_s = 1'b0;
            end
         endcase
      end else begin
         we1_s = 1'b0;
         we2_s = 1'b0;
      end
   end

   // Output registers; reset clears them at once and wins over a same-edge write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpO1_r <= {WIDTH{1'b0}};
         gpO2_r <= {WIDTH{1'b0}};
      end else begin
         if (we1_s) begin
            gpO1_r <= bus.WD;
         end
         if (we2_s) begin
            gpO2_r <= bus.WD;
         end
      end
   end

   // Combinational read-back; register reads return the pre-edge value during a write.
   always_comb begin
      rdMux_s = {WIDTH{1'b0}};
      case (bus.A)
         2'd0:    rdMux_s = gpI1;
         2'd1:    rdMux_s = gpI2;
         2'd2:    rdMux_s = gpO1_r;
         2'd3:    rdMux_s = gpO2_r;
         default: rdMux_s = {WIDTH{1'b0}};
      endcase
   end

   assign bus.RD = rdMux_s;
   assign gpO1   = gpO1_r;
   assign gpO2   = gpO2_r;

endmodule

// File: tb/tb_gpio_regs.sv
// Self-checking bench for gpio_regs: directed cases followed by randomized traffic against a register-map model.
module tb_gpio_regs;
   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic [W-1:0] gpI1;
   logic [W-1:0] gpI2;
   logic [W-1:0] gpO1;
   logic [W-1:0] gpO2;

   int checkCnt;
   int errCnt;

   // Model: the two writable registers as a plain array, indexed by (address - 2).
   logic [W-1:0] mOut[2];

   gpio_regs_if #(.WIDTH(W)) bus ();

   gpio_regs #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .gpI1 (gpI1),
      .gpI2 (gpI2),
      .gpO1 (gpO1),
      .gpO2 (gpO2)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checkCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] expRd(input logic [1:0] a);
      logic [W-1:0] space[4];
      space[0] = gpI1;
      space[1] = gpI2;
      space[2] = mOut[0];
      space[3] = mOut[1];
      return space[a];
   endfunction

   task automatic checkAll(input string tag);
      checkVal({tag, ".gpO1"}, gpO1, mOut[0]);
      checkVal({tag, ".gpO2"}, gpO2, mOut[1]);
      checkVal({tag, ".RD"}, bus.RD, expRd(bus.A));
   endtask

   // One clock edge; the model applies what the bus presented just before the edge.
   task automatic tick();
      logic         doW;
      logic [1:0]   a;
      logic [W-1:0] wd;
      logic         r;
      a   = bus.A;
      wd  = bus.WD;
      doW = bus.WE && (a >= 2'd2);
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
         mOut[0] = '0;
         mOut[1] = '0;
      end else if (doW) begin
         mOut[a - 2'd2] = wd;
      end
   endtask

   task automatic busSet(input logic [1:0] a, input logic we, input logic [W-1:0] wd);
      bus.A  = a;
      bus.WE = we;
      bus.WD = wd;
   endtask

   initial begin
      checkCnt = 0;
      errCnt   = 0;
      mOut[0]  = '0;
      mOut[1]  = '0;
      gpI1     = '0;
      gpI2     = '0;
      busSet(2'd2, 1'b0, '0);
      rst = 1'b1;
      #1;
      checkAll("por");
      tick();
      rst = 1'b0;
      tick();
      checkAll("postReset");

      // Load known values, then reset asynchronously between edges.
      busSet(2'd2, 1'b1, 32'hDEADBEEF); tick();
      busSet(2'd3, 1'b1, 32'h12345678); tick();
      busSet(2'd2, 1'b0, 32'h0); #1;
      checkAll("preload");
      #2;
      rst = 1'b1;
      mOut[0] = '0;
      mOut[1] = '0;
      #1;
      checkAll("asyncRstA2");
      bus.A = 2'd3; #1;
      checkAll("asyncRstA3");
      tick();
      rst = 1'b0;

      // Input reads need no edge.
      gpI1 = 32'hA5A5A5A5;
      gpI2 = 32'h5A5A5A5A;
      busSet(2'd0, 1'b0, '0); #1;
      checkVal("inRd0", bus.RD, 32'hA5A5A5A5);
      bus.A = 2'd1; #1;
      checkVal("inRd1", bus.RD, 32'h5A5A5A5A);

      // Output writes and readback.
      busSet(2'd2, 1'b1, 32'h00000055); tick();
      checkVal("wr1.gpO1", gpO1, 32'h00000055);
      checkVal("wr1.gpO2", gpO2, 32'h0);
      busSet(2'd3, 1'b1, 32'hFFFF0000); tick();
      checkVal("wr2.gpO2", gpO2, 32'hFFFF0000);
      checkVal("wr2.gpO1", gpO1, 32'h00000055);
      busSet(2'd2, 1'b0, '0); #1;
      checkVal("rb2", bus.RD, 32'h00000055);
      bus.A = 2'd3; #1;
      checkVal("rb3", bus.RD, 32'hFFFF0000);

      // Writes to read-only addresses and writes without WE are dropped.
      busSet(2'd0, 1'b1, 32'h11111111); tick();
      busSet(2'd1, 1'b1, 32'h11111111); tick();
      busSet(2'd2, 1'b0, 32'h22222222); tick();
      checkVal("ign.gpO1", gpO1, 32'h00000055);
      checkVal("ign.gpO2", gpO2, 32'hFFFF0000);

      // Read during write to the same register.
      busSet(2'd2, 1'b1, 32'h00000077); #1;
      checkVal("rdw.before", bus.RD, 32'h00000055);
      tick();
      bus.WE = 1'b0; #1;
      checkVal("rdw.after", bus.RD, 32'h00000077);

      // Reset beats a write on the same edge.
      busSet(2'd3, 1'b1, 32'h0000CAFE);
      rst = 1'b1;
      mOut[0] = '0;
      mOut[1] = '0;
      tick();
      checkVal("rstPrio.gpO2", gpO2, 32'h0);
      rst = 1'b0;
      tick();
      checkVal("rstPrio.rewrite", gpO2, 32'h0000CAFE);

      // Randomized traffic with occasional asynchronous reset pulses.
      busSet(2'd0, 1'b0, '0);
      tick();
      for (int i = 0; i < 300; i++) begin
         gpI1 = $urandom;
         gpI2 = $urandom;
         busSet(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
         #1;
         checkAll("rndPre");
         if ($urandom_range(0, 15) == 0) begin
            rst = 1'b1;
            mOut[0] = '0;
            mOut[1] = '0;
            #1;
            checkAll("rndRst");
         end
         tick();
         checkAll("rndPost");
         rst = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
      $finish;
   end

endmodule

// File: doc/gpio_regs.md
Name: gpio_regs

Overview:
- Two-port general-purpose I/O register block for the memory-mapped peripheral bus.
- Merges the address decoder function (gpio_ad) and the enabled D-register function (dreg_en) into one block, plus a read-back multiplexer.
- Provides two readable input ports and two writable/readable output registers at four word addresses selected by a 2-bit address.
- Sits behind the system address decoder; the bus supplies A, WE and WD, and the block returns RD.

Parameters:
- WIDTH, 32, data width of every data port and output register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  2  register address within the GPIO block.
- WE  input  1  bus write enable for the GPIO block.
- gpI1  input  WIDTH  general-purpose input port 1.
- gpI2  input  WIDTH  general-purpose input port 2.
- WD  input  WIDTH  bus write data.
- RD  output  WIDTH  bus read data (combinational).
- gpO1  output  WIDTH  general-purpose output register 1.
- gpO2  output  WIDTH  general-purpose output register 2.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Address map:
  - A=0: read gpI1; read-only.
  - A=1: read gpI2; read-only.
  - A=2: read/write gpO1.
  - A=3: read/write gpO2.
- Decode (purely combinational):
  - WE1 = WE & (A==2).
  - WE2 = WE & (A==3).
  - RdSel = A.
  - WE1 and WE2 are never both 1.
- Writes to A=0 or A=1 with WE=1 are silently ignored: no register changes, no error.
- Output registers (enabled D-register behaviour):
  - On rising clk with WE1=1, gpO1 <= WD; otherwise gpO1 holds. gpO2 behaves the same with WE2.
  - Write latency is one clock edge; gpO1/gpO2 drive the new value directly after that edge.
- Reset:
  - rst=1 forces gpO1=0 and gpO2=0 immediately, independent of clk.
  - While rst=1, writes are blocked.
  - Reset has priority over any write on the same edge.
  - After rst deasserts, registers hold 0 until written.
- Read mux (combinational, no latency):
  - A=0 -> RD=gpI1; A=1 -> RD=gpI2; A=2 -> RD=gpO1; A=3 -> RD=gpO2.
  - RD follows changes on A, gpI1 and gpI2 within the same cycle.
- Read during write to the same address: before the edge RD shows the old register value; after the edge it shows WD.
- Input ports are not registered or synchronised inside this block.
- No X propagation from an unused state; every 2-bit A value is fully decoded.

Test Plan:
- Reset: assert rst with registers holding 0xDEADBEEF/0x12345678, no clock edge -> gpO1=0, gpO2=0 immediately; RD at A=2 and A=3 reads 0.
- Input read: gpI1=0xA5A5A5A5, gpI2=0x5A5A5A5A, A=0 then A=1, WE=0 -> RD=0xA5A5A5A5 then 0x5A5A5A5A with no clock edge needed.
- Output write/readback: A=2, WE=1, WD=0x00000055, one edge -> gpO1=0x55, gpO2 unchanged. A=3, WD=0xFFFF0000, one edge -> gpO2=0xFFFF0000, gpO1 still 0x55. RD at A=2/A=3 returns 0x55/0xFFFF0000.
- Ignored writes: A=0 and A=1 with WE=1, WD=0x11111111 -> gpO1 and gpO2 unchanged. Also A=2, WE=0, WD=0x22222222 -> gpO1 unchanged.
- Same-cycle read/write: A=2, WE=1, WD=0x77, gpO1=0x55 -> RD=0x55 before the edge, 0x77 after.
- Reset priority: rst=1 on the same edge as A=3, WE=1, WD=0xCAFE -> gpO2=0. Deassert rst, then write 0xCAFE -> gpO2=0xCAFE after one edge.
